// File: rtl/fsab_responder.sv
// FSAB memory-side endpoint: credit-flow request queue, write-data queue and a byte-masked SRAM.
// Define FSAB_RESP_ERRCHK_EN to enable the sticky err output and queue-overflow / zero-length checks.
module fsab_responder #(
    parameter int FSAB_REQ_HI          = 0,
    parameter int FSAB_DID_HI          = 3,
    parameter int FSAB_ADDR_HI         = 30,
    parameter int FSAB_LEN_HI          = 2,
    parameter int FSAB_DATA_HI         = 63,
    parameter int FSAB_MASK_HI         = 7,
    parameter int FSAB_INITIAL_CREDITS = 4,
    parameter int MEM_WORDS_LOG2       = 10
) (
    input  logic                    clk,
    input  logic                    Nrst,
    input  logic                    fsabo_valid,
    input  logic [FSAB_REQ_HI:0]    fsabo_mode,
    input  logic [FSAB_DID_HI:0]    fsabo_did,
    input  logic [FSAB_DID_HI:0]    fsabo_subdid,
    input  logic [FSAB_ADDR_HI:0]   fsabo_addr,
    input  logic [FSAB_LEN_HI:0]    fsabo_len,
    input  logic [FSAB_DATA_HI:0]   fsabo_data,
    input  logic [FSAB_MASK_HI:0]   fsabo_mask,
    output logic                    fsabo_credit,
    output logic                    fsabi_valid,
    output logic [FSAB_DID_HI:0]    fsabi_did,
    output logic [FSAB_DID_HI:0]    fsabi_subdid,
    output logic [FSAB_DATA_HI:0]   fsabi_data,
    output logic                    err
);
    localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = (FSAB_REQ_HI + 1)'(1);
    localparam int REQ_AW   = (FSAB_INITIAL_CREDITS > 1) ? $clog2(FSAB_INITIAL_CREDITS) : 1;
    localparam int WD_DEPTH = 32;
    localparam int WD_AW    = 5;
    localparam int IDX_W    = MEM_WORDS_LOG2;

    typedef struct packed {
        logic [FSAB_REQ_HI:0]  mode;
        logic [FSAB_DID_HI:0]  did;
        logic [FSAB_DID_HI:0]  subdid;
        logic [IDX_W-1:0]      idx;
        logic [FSAB_LEN_HI:0]  len;
    } req_t;

    typedef struct packed {
        logic [FSAB_DATA_HI:0] data;
        logic [FSAB_MASK_HI:0] mask;
    } wd_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    req_t                  req_q [FSAB_INITIAL_CREDITS];
    logic [REQ_AW-1:0]     req_wp, req_rp;
    logic [REQ_AW:0]       req_cnt;
    wd_t                   wd_q [WD_DEPTH];
    logic [WD_AW-1:0]      wd_wp, wd_rp;
    logic [WD_AW:0]        wd_cnt;
    logic [FSAB_DATA_HI:0] mem [2**MEM_WORDS_LOG2];

    logic [FSAB_LEN_HI:0]  wr_left;
    logic                  burst_drop;
    state_t                state;
    logic [FSAB_LEN_HI:0]  cnt;
    logic [IDX_W-1:0]      idx;
    logic [FSAB_DID_HI:0]  cur_did, cur_subdid;

    req_t head, hdr_in;
    wd_t  wd_head, wd_in;
    logic hdr_beat, dat_beat, hdr_is_wr, req_full, wd_full, wd_want;
    logic req_push, req_pop, wd_push, wd_pop, mem_we;
    logic unused_addr;

    function automatic logic [REQ_AW-1:0] req_next(input logic [REQ_AW-1:0] p);
        return (p == REQ_AW'(FSAB_INITIAL_CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head    = req_q[req_rp];
    assign wd_head = wd_q[wd_rp];
    assign hdr_in  = '{mode: fsabo_mode, did: fsabo_did, subdid: fsabo_subdid,
                       idx: fsabo_addr[IDX_W+2:3], len: fsabo_len};
    assign wd_in   = '{data: fsabo_data, mask: fsabo_mask};
    assign unused_addr = &{1'b0, fsabo_addr[2:0], fsabo_addr[FSAB_ADDR_HI:IDX_W+3]};

    // A valid cycle is a data beat while a write burst is open, otherwise a header.
    assign dat_beat  = fsabo_valid && (wr_left != '0);
    assign hdr_beat  = fsabo_valid && (wr_left == '0);
    assign hdr_is_wr = (fsabo_mode == FSAB_WRITE);

    // The request in service still holds its credit, so it counts against queue capacity.
    assign req_full = ({1'b0, req_cnt} + {{(REQ_AW + 1){1'b0}}, (state != IDLE)})
                      >= (REQ_AW + 2)'(FSAB_INITIAL_CREDITS);
    assign wd_full  = (wd_cnt == (WD_AW + 1)'(WD_DEPTH));

    assign req_push = hdr_beat && !req_full;
    assign wd_want  = (dat_beat && !burst_drop) ||
                      (hdr_beat && hdr_is_wr && (fsabo_len != '0) && !req_full);
    assign wd_push  = wd_want && !wd_full;
    assign wd_pop   = (state == WRITE);
    assign mem_we   = (state == WRITE);

    always_comb begin
        req_pop = 1'b0;
        if (state == IDLE && req_cnt != '0)
            req_pop = (head.len == '0) || (head.mode != FSAB_WRITE) ||
                      (wd_cnt >= (WD_AW + 1)'(head.len));
    end

    always_ff @(posedge clk) begin
        if (req_push) req_q[req_wp] <= hdr_in;
        if (wd_push)  wd_q[wd_wp]   <= wd_in;
        if (mem_we)
            for (int b = 0; b <= FSAB_MASK_HI; b++)
                if (wd_head.mask[b]) mem[idx][8*b +: 8] <= wd_head.data[8*b +: 8];
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            req_wp       <= '0;
            req_rp       <= '0;
            req_cnt      <= '0;
            wd_wp        <= '0;
            wd_rp        <= '0;
            wd_cnt       <= '0;
            wr_left      <= '0;
            burst_drop   <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            cur_did      <= '0;
            cur_subdid   <= '0;
            fsabo_credit <= 1'b0;
            fsabi_valid  <= 1'b0;
            fsabi_did    <= '0;
            fsabi_subdid <= '0;
            fsabi_data   <= '0;
        end else begin
            if (req_push) req_wp <= req_next(req_wp);
            if (req_pop)  req_rp <= req_next(req_rp);
            if (req_push && !req_pop)      req_cnt <= req_cnt + 1'b1;
            else if (!req_push && req_pop) req_cnt <= req_cnt - 1'b1;

            if (wd_push) wd_wp <= wd_wp + 1'b1;
            if (wd_pop)  wd_rp <= wd_rp + 1'b1;
            if (wd_push && !wd_pop)      wd_cnt <= wd_cnt + 1'b1;
            else if (!wd_push && wd_pop) wd_cnt <= wd_cnt - 1'b1;

            // A dropped write header still frames its burst so later headers stay aligned.
            if (hdr_beat && hdr_is_wr && fsabo_len != '0) begin
                wr_left    <= fsabo_len - 1'b1;
                burst_drop <= req_full;
            end else if (dat_beat) begin
                wr_left <= wr_left - 1'b1;
            end

            fsabo_credit <= 1'b0;
            fsabi_valid  <= 1'b0;
            case (state)
                IDLE: if (req_pop) begin
                    cnt        <= head.len;
                    idx        <= head.idx;
                    cur_did    <= head.did;
                    cur_subdid <= head.subdid;
                    if (head.len == '0)              fsabo_credit <= 1'b1;
                    else if (head.mode == FSAB_WRITE) state <= WRITE;
                    else                              state <= READ;
                end
                WRITE: begin
                    idx <= idx + 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == (FSAB_LEN_HI + 1)'(1)) begin
                        fsabo_credit <= 1'b1;
                        state        <= IDLE;
                    end
                end
                READ: begin
                    fsabi_valid  <= 1'b1;
                    fsabi_data   <= mem[idx];
                    fsabi_did    <= cur_did;
                    fsabi_subdid <= cur_subdid;
                    idx          <= idx + 1'b1;
                    cnt          <= cnt - 1'b1;
                    if (cnt == (FSAB_LEN_HI + 1)'(1)) begin
                        fsabo_credit <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FSAB_RESP_ERRCHK_EN
    logic err_ev;
    assign err_ev = (hdr_beat && req_full) || (wd_want && wd_full) ||
                    (req_pop && head.len == '0);

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst)       err <= 1'b0;
        else if (err_ev) err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Nrst)
            assert (!err_ev) else $error("fsab_responder: queue overflow or zero-length request");
    end
`else
    assign err = 1'b0;
`endif

endmodule
